// File: rtl/main_mem_responder.sv
// main_mem_responder: block-granular main-memory model answering cache
// refill reads (valid_mem pulse + data) and dirty-block write-backs
// (ready_mem pulse) after a fixed latency.
// Optional build macro MEM_STALL_INJECT_EN adds LFSR-driven response stalls.
module main_mem_responder #(
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE,
  parameter int ADDR_WIDTH      = 30,
  parameter int MEM_BLOCKS      = 256,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en_mem,
  input  logic                  write_en_mem,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [BLOCK_SIZE-1:0] dirty_block_in,
  output logic [BLOCK_SIZE-1:0] data_out_mem,
  output logic                  valid_mem,
  output logic                  ready_mem
);

  localparam int IDX_W   = $clog2(MEM_BLOCKS);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_RESP = 3'd3,
    S_WR_RESP = 3'd4
  } state_t;

  // Backing store; never reset, benches preload it hierarchically.
  logic [BLOCK_SIZE-1:0] mem [MEM_BLOCKS];

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [BLOCK_SIZE-1:0] r_wdata;
  logic [BLOCK_SIZE-1:0] r_data_out;

  logic w_accept_wr;
  logic w_accept_rd;
  logic w_rd_fire;
  logic w_wr_fire;
  logic w_cnt_dec;
  logic w_stall;
  logic w_unused_addr;

  // Upper address bits alias onto the same block; only the index is used.
  assign w_unused_addr = ^mem_addr;

`ifdef MEM_STALL_INJECT_EN
  logic [7:0] r_lfsr;

  // Free-running Fibonacci LFSR (taps 8,6,5,4) that randomly defers responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // Write-back wins over refill when both are requested together.
  assign w_accept_wr = (r_state == S_IDLE) && write_en_mem;
  assign w_accept_rd = (r_state == S_IDLE) && !write_en_mem && read_en_mem;
  assign w_rd_fire   = (r_state == S_RD_WAIT) && read_en_mem  && (r_cnt == '0) && !w_stall;
  assign w_wr_fire   = (r_state == S_WR_WAIT) && write_en_mem && (r_cnt == '0) && !w_stall;
  assign w_cnt_dec   = (((r_state == S_RD_WAIT) && read_en_mem) ||
                        ((r_state == S_WR_WAIT) && write_en_mem)) && (r_cnt != '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a dropped request aborts a wait without response.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept_wr)      w_state_next = S_WR_WAIT;
        else if (w_accept_rd) w_state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (!read_en_mem)   w_state_next = S_IDLE;
        else if (w_rd_fire) w_state_next = S_RD_RESP;
      end
      S_WR_WAIT: begin
        if (!write_en_mem)  w_state_next = S_IDLE;
        else if (w_wr_fire) w_state_next = S_WR_RESP;
      end
      S_RD_RESP: w_state_next = S_IDLE;
      S_WR_RESP: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Response pulses are decoded from the registered state, so they are glitch-free
  // and cleared immediately by reset.
  always_comb begin
    valid_mem    = (r_state == S_RD_RESP);
    ready_mem    = (r_state == S_WR_RESP);
    data_out_mem = r_data_out;
  end

  // Request latch, latency counter and read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_accept_wr) begin
        r_idx   <= mem_addr[IDX_W-1:0];
        r_wdata <= dirty_block_in;
        r_cnt   <= WR_LOAD;
      end else if (w_accept_rd) begin
        r_idx <= mem_addr[IDX_W-1:0];
        r_cnt <= RD_LOAD;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_rd_fire) begin
        r_data_out <= mem[r_idx];
      end
    end
  end

  // Store commit on the edge that enters WR_RESP; aborts and resets never get here.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      mem[r_idx] <= r_wdata;
    end
  end

endmodule
